multilane_serializer: RTL and testbench

MULTILANE_SERIALIZER -- requirements
Module: multilane_serializer

---
 rtl/ser_pkg.sv | 78 +++++++
 rtl/enc_8b10b.sv | 69 ++++++
 rtl/multilane_serializer.sv | 132 +++++++++++++
 tb/tb_multilane_serializer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/ser_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ser_pkg
// Description : Shared types, symbol constants and 8b/10b code tables for the
//               multilane serializer.
// Revision    : 1.0 - initial release
// ============================================================================
package ser_pkg;

    typedef enum logic [0:0] {
        ST_ALIGN = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam int SYM_W = 10;

    localparam logic [SYM_W-1:0] K285_RDN  = 10'h17C;
    localparam logic [SYM_W-1:0] K285_RDP  = 10'h283;
    localparam logic [SYM_W-1:0] D215_CODE = 10'h155;

    // 5b/6b codes for RD-, written abcdei with 'a' as the MSB of the literal
    function automatic logic [5:0] tab6(input logic [4:0] x);
        logic [5:0] c;
        case (x)
            5'd0:    c = 6'b100111;
            5'd1:    c = 6'b011101;
            5'd2:    c = 6'b101101;
            5'd3:    c = 6'b110001;
            5'd4:    c = 6'b110101;
            5'd5:    c = 6'b101001;
            5'd6:    c = 6'b011001;
            5'd7:    c = 6'b111000;
            5'd8:    c = 6'b111001;
            5'd9:    c = 6'b100101;
            5'd10:   c = 6'b010101;
            5'd11:   c = 6'b110100;
            5'd12:   c = 6'b001101;
            5'd13:   c = 6'b101100;
            5'd14:   c = 6'b011100;
            5'd15:   c = 6'b010111;
            5'd16:   c = 6'b011011;
            5'd17:   c = 6'b100011;
            5'd18:   c = 6'b010011;
            5'd19:   c = 6'b110010;
            5'd20:   c = 6'b001011;
            5'd21:   c = 6'b101010;
            5'd22:   c = 6'b011010;
            5'd23:   c = 6'b111010;
            5'd24:   c = 6'b110011;
            5'd25:   c = 6'b100110;
            5'd26:   c = 6'b010110;
            5'd27:   c = 6'b110110;
            5'd28:   c = 6'b001110;
            5'd29:   c = 6'b101110;
            5'd30:   c = 6'b011110;
            default: c = 6'b101011;
        endcase
        return c;
    endfunction

    // 3b/4b primary codes for RD-, written fghj with 'f' as the MSB
    function automatic logic [3:0] tab4(input logic [2:0] y);
        logic [3:0] c;
        case (y)
            3'd0:    c = 4'b1011;
            3'd1:    c = 4'b1001;
            3'd2:    c = 4'b0101;
            3'd3:    c = 4'b1100;
            3'd4:    c = 4'b1101;
            3'd5:    c = 4'b1010;
            3'd6:    c = 4'b0110;
            default: c = 4'b1110;
        endcase
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/enc_8b10b.sv
`default_nettype none
// ============================================================================
// Module      : enc_8b10b
// Description : Combinational 8b/10b encoder with per-sub-block disparity.
// Revision    : 1.0 - initial release
// ============================================================================
module enc_8b10b
    import ser_pkg::*;
(
    input  logic [7:0]       data_i,
    input  logic             k_i,
    input  logic             rd_i,
    output logic [SYM_W-1:0] code10_o,
    output logic             rd_o,
    output logic             k_err_o
);

    logic [4:0] x;
    logic [2:0] y;
    logic [5:0] base6;
    logic [5:0] s6;
    logic [3:0] base4;
    logic [3:0] s4;
    logic       rd_mid;
    logic       k_ok;
    logic       use_a7;
    logic       comp4;

    always_comb begin
        k_ok = (data_i[4:0] == 5'd28) ||
               ((data_i[7:5] == 3'd7) &&
                ((data_i[4:0] == 5'd23) || (data_i[4:0] == 5'd27) ||
                 (data_i[4:0] == 5'd29) || (data_i[4:0] == 5'd30)));
        k_err_o = k_i && !k_ok;

        // an unsupported control byte is replaced by K28.5
        x = k_err_o ? 5'd28 : data_i[4:0];
        y = k_err_o ? 3'd5  : data_i[7:5];

        base6  = (k_i && (x == 5'd28)) ? 6'b001111 : tab6(x);
        s6     = (rd_i && (($countones(base6) != 3) || (x == 5'd7))) ? ~base6 : base6;
        rd_mid = rd_i ^ ($countones(base6) != 3);

        use_a7 = (y == 3'd7) &&
                 (k_i ||
                  (!rd_mid && ((x == 5'd17) || (x == 5'd18) || (x == 5'd20))) ||
                  ( rd_mid && ((x == 5'd11) || (x == 5'd13) || (x == 5'd14))));
        base4  = use_a7 ? 4'b0111 : tab4(y);

        // control characters also invert the neutral x.1/x.2/x.5/x.6 codes at RD-
        if (rd_mid) begin
            comp4 = ($countones(base4) != 2) || (y == 3'd3);
        end else begin
            comp4 = k_i && ($countones(base4) == 2) && (y != 3'd3);
        end
        s4   = comp4 ? ~base4 : base4;
        rd_o = rd_mid ^ ($countones(base4) != 2);

        code10_o = '0;
        for (int b = 0; b < 6; b++) begin
            code10_o[b] = s6[5-b];
        end
        for (int b = 0; b < 4; b++) begin
            code10_o[6+b] = s4[3-b];
        end
    end

endmodule
`default_nettype wire

// File: rtl/multilane_serializer.sv
`default_nettype none
// ============================================================================
// Module      : multilane_serializer
// Description : Lockstep multi-lane 8b/10b serializer with comma alignment.
// Revision    : 1.0 - initial release
// ============================================================================
module multilane_serializer
    import ser_pkg::*;
#(
    parameter int NUM_LANES  = 2,
    parameter int ALIGN_SYMS = 4,
    parameter int IDLE_COMMA = 1
)(
    input  logic                       i_Clk,
    input  logic                       i_rst,
    input  logic [8*NUM_LANES-1:0]     i_Data,
    input  logic [NUM_LANES-1:0]       i_K,
    input  logic                       i_Valid,
    output logic                       o_Ready,
    output logic [NUM_LANES-1:0]       o_Ser,
    output logic [SYM_W*NUM_LANES-1:0] o_10B,
    output logic [NUM_LANES-1:0]       o_RD,
    output logic [NUM_LANES-1:0]       o_K_Err,
    output logic                       o_Aligned
);

    localparam int             AW         = (ALIGN_SYMS > 1) ? $clog2(ALIGN_SYMS) : 1;
    localparam logic [AW-1:0]  ALIGN_LAST = AW'(ALIGN_SYMS - 1);
    localparam logic [3:0]     CNT_LAST   = 4'd9;

    state_t          state_q;
    state_t          state_d;
    logic [AW-1:0]   align_q;
    logic [AW-1:0]   align_d;
    logic [3:0]      cnt_q;
    logic            sym_edge;
    logic            accept;
    logic            use_comma;

    assign sym_edge = (cnt_q == CNT_LAST);

    always_ff @(posedge i_Clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_ALIGN;
            align_q <= '0;
        end else begin
            state_q <= state_d;
            align_q <= align_d;
        end
    end

    always_comb begin
        state_d = state_q;
        align_d = align_q;
        if ((state_q == ST_ALIGN) && sym_edge) begin
            align_d = align_q + 1'b1;
            if (align_q == ALIGN_LAST) begin
                state_d = ST_RUN;
            end
        end
    end

    always_comb begin
        o_Aligned = (state_q == ST_RUN);
        o_Ready   = (state_q == ST_RUN) && sym_edge;
        accept    = o_Ready && i_Valid;
        use_comma = (state_q == ST_ALIGN) || (IDLE_COMMA != 0);
    end

    // reset parks the counter on 9 so the first edge after release loads
    always_ff @(posedge i_Clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= CNT_LAST;
        end else begin
            cnt_q <= sym_edge ? 4'd0 : cnt_q + 4'd1;
        end
    end

    for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
        logic [SYM_W-1:0] sym_q;
        logic [SYM_W-1:0] sym_d;
        logic             rd_q;
        logic             rd_d;
        logic             kerr_q;
        logic [SYM_W-1:0] enc_code;
        logic             enc_rd;
        logic             enc_kerr;

        enc_8b10b u_enc (
            .data_i   (i_Data[8*n +: 8]),
            .k_i      (i_K[n]),
            .rd_i     (rd_q),
            .code10_o (enc_code),
            .rd_o     (enc_rd),
            .k_err_o  (enc_kerr)
        );

        always_comb begin
            if (accept) begin
                sym_d = enc_code;
                rd_d  = enc_rd;
            end else if (use_comma) begin
                sym_d = rd_q ? K285_RDP : K285_RDN;
                rd_d  = ~rd_q;
            end else begin
                sym_d = D215_CODE;
                rd_d  = rd_q;
            end
        end

        always_ff @(posedge i_Clk or posedge i_rst) begin
            if (i_rst) begin
                sym_q  <= '0;
                rd_q   <= 1'b0;
                kerr_q <= 1'b0;
            end else begin
                kerr_q <= accept && enc_kerr;
                if (sym_edge) begin
                    sym_q <= sym_d;
                    rd_q  <= rd_d;
                end
            end
        end

        assign o_Ser[n]                 = sym_q[cnt_q];
        assign o_10B[SYM_W*n +: SYM_W]  = sym_q;
        assign o_RD[n]                  = rd_q;
        assign o_K_Err[n]               = kerr_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_multilane_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_multilane_serializer
// Description : Scoreboard bench: directed words with hand-derived 10b codes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multilane_serializer;

    logic        i_Clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [15:0] i_Data = '0;
    logic [1:0]  i_K = '0;
    logic        i_Valid = 1'b0;
    logic        o_Ready;
    logic [1:0]  o_Ser;
    logic [19:0] o_10B;
    logic [1:0]  o_RD;
    logic [1:0]  o_K_Err;
    logic        o_Aligned;

    typedef struct packed {
        logic [19:0] code;
        logic [1:0]  rd;
        logic [1:0]  kerr;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   maxrun = 0;

    always #5 i_Clk = ~i_Clk;

    multilane_serializer #(
        .NUM_LANES  (2),
        .ALIGN_SYMS (4),
        .IDLE_COMMA (0)
    ) dut (
        .i_Clk     (i_Clk),
        .i_rst     (i_rst),
        .i_Data    (i_Data),
        .i_K       (i_K),
        .i_Valid   (i_Valid),
        .o_Ready   (o_Ready),
        .o_Ser     (o_Ser),
        .o_10B     (o_10B),
        .o_RD      (o_RD),
        .o_K_Err   (o_K_Err),
        .o_Aligned (o_Aligned)
    );

    function automatic exp_t mk(input logic [19:0] c, input logic [1:0] r, input logic [1:0] k);
        exp_t e;
        e.code = c;
        e.rd   = r;
        e.kerr = k;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, got, want);
        end
    endtask

    task automatic push_align();
        sbq.push_back(mk({10'h17C, 10'h17C}, 2'b11, 2'b00));
        sbq.push_back(mk({10'h283, 10'h283}, 2'b00, 2'b00));
        sbq.push_back(mk({10'h17C, 10'h17C}, 2'b11, 2'b00));
        sbq.push_back(mk({10'h283, 10'h283}, 2'b00, 2'b00));
    endtask

    // offer one slot's inputs, wait for the load slot, record what it must produce
    task automatic send(input bit v, input logic [15:0] d, input logic [1:0] kk,
                        input logic [19:0] code, input logic [1:0] rd, input logic [1:0] ke);
        int n;
        i_Valid = v;
        i_Data  = d;
        i_K     = kk;
        n = 0;
        while (!o_Ready && n < 60) begin
            @(negedge i_Clk);
            n++;
        end
        if (!o_Ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout got o_Ready=0 want 1 within 60 cycles");
        end else begin
            sbq.push_back(mk(code, rd, ke));
        end
        @(posedge i_Clk);
        @(negedge i_Clk);
        i_Valid = 1'b0;
    endtask

    // monitor: one expected entry per load, then nine bit-times of serial checks
    initial begin
        int        mph;
        bit        have;
        bit        symerr;
        exp_t      cur;
        int        run [2];
        logic [1:0] last;
        mph    = 0;
        have   = 1'b0;
        symerr = 1'b0;
        cur    = '0;
        last   = '0;
        run[0] = 0;
        run[1] = 0;
        forever begin
            @(posedge i_Clk);
            #1;
            if (i_rst) begin
                mph    = 0;
                have   = 1'b0;
                run[0] = 0;
                run[1] = 0;
                continue;
            end
            for (int l = 0; l < 2; l++) begin
                if (run[l] != 0 && o_Ser[l] == last[l]) run[l]++;
                else run[l] = 1;
                last[l] = o_Ser[l];
                if (run[l] > maxrun) maxrun = run[l];
            end
            if (mph == 0) begin
                symerr = 1'b0;
                if (sbq.size() == 0) begin
                    have = 1'b0;
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow got load with empty queue want none");
                end else begin
                    cur  = sbq.pop_front();
                    have = 1'b1;
                    chk("sym_code_rd_kerr", {8'h0, o_10B, o_RD, o_K_Err}, {8'h0, cur});
                end
            end else if (have) begin
                if (o_10B !== cur.code || o_RD !== cur.rd || o_K_Err !== 2'b00) symerr = 1'b1;
            end
            if (have) begin
                for (int l = 0; l < 2; l++) begin
                    if (o_Ser[l] !== cur.code[10*l + mph]) symerr = 1'b1;
                end
            end
            if (mph == 9 && have) chk("serial_and_hold", {31'h0, symerr}, 32'h0);
            mph = (mph == 9) ? 0 : mph + 1;
        end
    end

    initial begin
        bit rdy_seen;
        repeat (3) @(negedge i_Clk);
        chk("reset_state", {4'h0, o_Ser, o_10B, o_RD, o_K_Err, o_Ready, o_Aligned}, 32'h0);
        push_align();
        i_rst = 1'b0;

        rdy_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (o_Ready) rdy_seen = 1'b1;
            if (i == 30) chk("aligned_before_load4", {31'h0, o_Aligned}, 32'h0);
            if (i == 31) chk("aligned_after_load4", {31'h0, o_Aligned}, 32'h1);
            @(negedge i_Clk);
        end
        chk("ready_low_during_align", {31'h0, rdy_seen}, 32'h0);
        chk("ready_after_align", {31'h0, o_Ready}, 32'h1);

        //    valid  data      k      {lane1,lane0} codes       rd     kerr
        send(1'b1, 16'hF1_00, 2'b00, {10'h3B1, 10'h0B9}, 2'b10, 2'b00);
        send(1'b1, 16'hBC_00, 2'b11, {10'h283, 10'h17C}, 2'b01, 2'b01);
        send(1'b0, 16'hFF_FF, 2'b11, {10'h155, 10'h155}, 2'b01, 2'b00);
        send(1'b0, 16'hFF_FF, 2'b11, {10'h155, 10'h155}, 2'b01, 2'b00);
        send(1'b0, 16'hFF_FF, 2'b11, {10'h155, 10'h155}, 2'b01, 2'b00);
        send(1'b1, 16'hEB_F1, 2'b00, {10'h1CB, 10'h231}, 2'b10, 2'b00);
        send(1'b1, 16'hEB_83, 2'b00, {10'h04B, 10'h2E3}, 2'b01, 2'b00);
        send(1'b1, 16'h3C_FC, 2'b11, {10'h27C, 10'h383}, 2'b11, 2'b00);
        send(1'b1, 16'hF7_00, 2'b10, {10'h3A8, 10'h346}, 2'b11, 2'b00);
        send(1'b1, 16'hFD_B5, 2'b10, {10'h3A2, 10'h155}, 2'b11, 2'b00);
        send(1'b1, 16'h1B_7C, 2'b11, {10'h283, 10'h0C3}, 2'b00, 2'b10);
        send(1'b1, 16'h0E_4A, 2'b00, {10'h34E, 10'h2AA}, 2'b10, 2'b00);
        send(1'b1, 16'hF4_E0, 2'b00, {10'h234, 10'h239}, 2'b00, 2'b00);

        // abort the idle symbol that follows, four bit-times into it
        repeat (4) @(posedge i_Clk);
        #2;
        i_rst = 1'b1;
        #1;
        chk("reset_mid_symbol", {4'h0, o_Ser, o_10B, o_RD, o_K_Err, o_Ready, o_Aligned}, 32'h0);
        repeat (2) @(negedge i_Clk);
        push_align();
        i_rst = 1'b0;

        send(1'b1, 16'h00_00, 2'b00, {10'h0B9, 10'h0B9}, 2'b00, 2'b00);
        repeat (9) @(posedge i_Clk);
        #3;
        chk("queue_drained", sbq.size(), 32'h0);
        chk("max_run_le_5", {31'h0, (maxrun > 5)}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got no finish want finish before 100000ns");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
